// File: rtl/pe_pkg.sv
// Shared PE types: unary op codes and the per-operand side info that travels
// from the variable generator to var_restore.
package pe_pkg;

  localparam int PE_MUL_BW = 16;
  localparam int PE_FRA_BW = 10;
  localparam int PE_XI_BW  = PE_MUL_BW - PE_FRA_BW;

  typedef enum logic [1:0] {
    UNO_GEMM = 2'b00,
    UNO_DIV  = 2'b01,
    UNO_EXP  = 2'b10,
    UNO_LOG  = 2'b11
  } uno_op_e;

  // An all-zero entry decodes as a plain gemm pass-through.
  typedef struct packed {
    uno_op_e                op;
    logic [4:0]             s;
    logic [PE_XI_BW-1:0]    xi;
    logic                   x_le0;
  } side_info_t;

endpackage

// File: rtl/var_restore_if.sv
// Operand/result bus between the PE datapath and var_restore.
interface var_restore_if #(parameter int MUL_BW = 16);

  logic [1:0]               gemm_uno;
  logic signed [MUL_BW-1:0] x_i;
  logic                     x_vld_i;
  logic signed [MUL_BW-1:0] res_i;
  logic                     res_vld_i;
  logic                     err_clr_i;
  logic signed [MUL_BW-1:0] res_o;
  logic                     res_vld_o;
  logic                     ovf_o;
  logic                     full_o;
  logic [1:0]               err_o;

  modport master (
    output gemm_uno, x_i, x_vld_i, res_i, res_vld_i, err_clr_i,
    input  res_o, res_vld_o, ovf_o, full_o, err_o
  );

  modport slave (
    input  gemm_uno, x_i, x_vld_i, res_i, res_vld_i, err_clr_i,
    output res_o, res_vld_o, ovf_o, full_o, err_o
  );

endinterface

// File: rtl/priority_enc_16.sv
// Leading-zero count of a 16-bit word; an all-zero word reports 16.
module priority_enc_16 (
  input  logic [15:0] din,
  output logic [4:0]  lz
);

  always_comb begin
    lz = 5'd16;
    for (int i = 0; i < 16; i++) begin
      if (din[i]) lz = 5'(15 - i);
    end
  end

endmodule

// File: rtl/uno_side_fifo.sv
// Synchronous side-info FIFO; a push into a full FIFO survives only when a pop
// frees a slot in the same cycle, and a pop never sees a same-cycle push.
module uno_side_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [7:0]
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  T     din,
  input  logic pop,
  output T     dout,
  output logic full,
  output logic empty,
  output logic drop,
  output logic under
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  T            mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign drop    = push & full & ~do_pop;
  assign under   = pop & empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/var_restore.sv
// Rescales polynomial results back to true div/exp/log values (base 2) using
// side info captured when the operand entered the generator.
module var_restore
  import pe_pkg::*;
#(
  parameter int INT_BW = 5,
  parameter int FRA_BW = 10,
  parameter int MUL_BW = 16,
  parameter int DEPTH  = 4
) (
  input logic           clk,
  input logic           rst_n,
  var_restore_if.slave  bus
);

  localparam int WIDE = MUL_BW + 16;
  localparam logic signed [WIDE-1:0] SAT_MAX = {{(WIDE-MUL_BW+1){1'b0}}, {(MUL_BW-1){1'b1}}};
  localparam logic signed [WIDE-1:0] SAT_MIN = {{(WIDE-MUL_BW+1){1'b1}}, {(MUL_BW-1){1'b0}}};

  // Result is {ovf, value}.
  function automatic logic [MUL_BW:0] saturate(input logic signed [WIDE-1:0] v);
    if (v > SAT_MAX) return {1'b1, SAT_MAX[MUL_BW-1:0]};
    if (v < SAT_MIN) return {1'b1, SAT_MIN[MUL_BW-1:0]};
    return {1'b0, v[MUL_BW-1:0]};
  endfunction

  // Any nonzero value shifted left by 16 or more is already out of range.
  function automatic logic [MUL_BW:0] shift_sat(input logic signed [MUL_BW-1:0] r,
                                                input logic signed [7:0]        k);
    logic signed [WIDE-1:0] w;
    logic [7:0]             amt;
    w = WIDE'(r);
    if (k < 8'sd0) begin
      amt = 8'(-k);
      return saturate(w >>> amt);
    end
    if (k >= 8'sd16) begin
      if (r == '0) return '0;
      return r[MUL_BW-1] ? {1'b1, SAT_MIN[MUL_BW-1:0]} : {1'b1, SAT_MAX[MUL_BW-1:0]};
    end
    return saturate(w <<< k[3:0]);
  endfunction

  logic [4:0]  lz;
  side_info_t  push_info, pop_info;
  logic        fifo_full, fifo_empty, fifo_drop, fifo_under;

  priority_enc_16 u_penc (
    .din (bus.x_i),
    .lz  (lz)
  );

  always_comb begin
    push_info.op    = uno_op_e'(bus.gemm_uno);
    push_info.s     = lz;
    push_info.xi    = bus.x_i[MUL_BW-1:FRA_BW];
    push_info.x_le0 = bus.x_i[MUL_BW-1] | (bus.x_i == '0);
  end

  uno_side_fifo #(.DEPTH(DEPTH), .T(side_info_t)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (bus.x_vld_i),
    .din   (push_info),
    .pop   (bus.res_vld_i),
    .dout  (pop_info),
    .full  (fifo_full),
    .empty (fifo_empty),
    .drop  (fifo_drop),
    .under (fifo_under)
  );

  assign bus.full_o = fifo_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.err_o <= 2'b00;
    else        bus.err_o <= (bus.err_clr_i ? 2'b00 : bus.err_o) | {fifo_drop, fifo_under};
  end

  // Stage A: pop side info alongside the raw result; empty pops become gemm.
  logic                     vld_p0;
  logic signed [MUL_BW-1:0] res_p0;
  side_info_t               side_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p0 <= 1'b0;
    else        vld_p0 <= bus.res_vld_i;
  end

  always_ff @(posedge clk) begin
    if (bus.res_vld_i) begin
      res_p0  <= bus.res_i;
      side_p0 <= fifo_empty ? '0 : pop_info;
    end
  end

  // Stage B: shift / offset and saturate.
  logic signed [7:0]      k_div, k_exp;
  logic signed [WIDE-1:0] log_sum;
  logic [MUL_BW:0]        stage_b;

  assign k_div   = 8'(side_p0.s) - 8'(INT_BW);
  assign k_exp   = 8'(signed'(side_p0.xi));
  assign log_sum = WIDE'(res_p0) + ((WIDE'(INT_BW) - WIDE'(side_p0.s)) <<< FRA_BW);

  always_comb begin
    stage_b = {1'b0, res_p0};
    case (side_p0.op)
      UNO_DIV: stage_b = side_p0.x_le0 ? {1'b1, SAT_MAX[MUL_BW-1:0]} : shift_sat(res_p0, k_div);
      UNO_EXP: stage_b = shift_sat(res_p0, k_exp);
      UNO_LOG: stage_b = side_p0.x_le0 ? {1'b1, SAT_MIN[MUL_BW-1:0]} : saturate(log_sum);
      default: stage_b = {1'b0, res_p0};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.res_vld_o <= 1'b0;
      bus.res_o     <= '0;
      bus.ovf_o     <= 1'b0;
    end else begin
      bus.res_vld_o <= vld_p0;
      if (vld_p0) {bus.ovf_o, bus.res_o} <= stage_b;
    end
  end

endmodule
